// File: rtl/pmul_ladder_ctrl.sv
// Montgomery-ladder scalar multiplication controller.
// Computes Q = k*P by sequencing an external point unit (add/double) over a
// request/done handshake. No field arithmetic lives here; the point unit must
// accept the infinity point INF = (1, 1, 0) as an ordinary operand.
module pmul_ladder_ctrl #(
  parameter int W          = 256,
  parameter int KW         = 256,
  parameter int CONST_TIME = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [KW-1:0] k,
  input  logic [W-1:0]  x1,
  input  logic [W-1:0]  y1,
  input  logic [W-1:0]  z1,
  output logic [W-1:0]  x2,
  output logic [W-1:0]  y2,
  output logic [W-1:0]  z2,
  output logic          busy,
  output logic          done,
  output logic          pu_start,
  output logic          pu_op,
  output logic [W-1:0]  pu_ax,
  output logic [W-1:0]  pu_ay,
  output logic [W-1:0]  pu_az,
  output logic [W-1:0]  pu_bx,
  output logic [W-1:0]  pu_by,
  output logic [W-1:0]  pu_bz,
  input  logic          pu_done,
  input  logic [W-1:0]  pu_rx,
  input  logic [W-1:0]  pu_ry,
  input  logic [W-1:0]  pu_rz
);

  localparam int IW = (KW > 1) ? $clog2(KW) : 1;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } point_t;

  localparam point_t INF = {W'(1), W'(1), W'(0)};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ADD_REQ,
    S_ADD_WAIT,
    S_DBL_REQ,
    S_DBL_WAIT,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] kreg_q, kreg_d;
  logic [IW-1:0] idx_q, idx_d;
  point_t        r0_q, r0_d;
  point_t        r1_q, r1_d;
  point_t        t_q, t_d;
  point_t        res_q, res_d;
  point_t        pu_a_q, pu_a_d;
  point_t        pu_b_q, pu_b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pu_start_q, pu_start_d;
  logic          pu_op_q, pu_op_d;

  logic          enter_add;
  logic          enter_finish;
  point_t        p_in;
  point_t        pu_r;

  assign p_in = {x1, y1, z1};
  assign pu_r = {pu_rx, pu_ry, pu_rz};

  // Next-state and datapath updates. Request pulses, operands and the done
  // pulse are registered on entry to their state so they are glitch-free and
  // the operands stay put for the whole wait window.
  always_comb begin
    state_d      = state_q;
    kreg_d       = kreg_q;
    idx_d        = idx_q;
    r0_d         = r0_q;
    r1_d         = r1_q;
    t_d          = t_q;
    res_d        = res_q;
    pu_a_d       = pu_a_q;
    pu_b_d       = pu_b_q;
    pu_op_d      = pu_op_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pu_start_d   = 1'b0;
    enter_add    = 1'b0;
    enter_finish = 1'b0;

    if (abort) begin
      // Cancel wins over everything, including a same-cycle start in IDLE.
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            kreg_d = k;
            r0_d   = INF;
            r1_d   = p_in;
            idx_d  = IW'(KW - 1);
            busy_d = 1'b1;
            // The top bit is examined in the start cycle itself, so a
            // variable-time scan spends exactly one cycle per leading zero.
            if (CONST_TIME != 0 || k[KW-1]) begin
              enter_add = 1'b1;
            end else if (KW == 1) begin
              enter_finish = 1'b1;
            end else begin
              state_d = S_SCAN;
              idx_d   = IW'(KW - 2);
            end
          end
        end
        S_SCAN: begin
          if (kreg_q[idx_q]) begin
            enter_add = 1'b1;
          end else if (idx_q == '0) begin
            enter_finish = 1'b1;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
        S_ADD_REQ: state_d = S_ADD_WAIT;
        S_ADD_WAIT: begin
          if (pu_done) begin
            t_d        = pu_r;
            state_d    = S_DBL_REQ;
            pu_start_d = 1'b1;
            pu_op_d    = 1'b0;
            pu_a_d     = kreg_q[idx_q] ? r1_q : r0_q;
          end
        end
        S_DBL_REQ: state_d = S_DBL_WAIT;
        S_DBL_WAIT: begin
          if (pu_done) begin
            if (kreg_q[idx_q]) begin
              r0_d = t_q;
              r1_d = pu_r;
            end else begin
              r1_d = t_q;
              r0_d = pu_r;
            end
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx_q == '0) begin
            enter_finish = 1'b1;
          end else begin
            idx_d     = idx_q - IW'(1);
            enter_add = 1'b1;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase

      if (enter_add) begin
        state_d    = S_ADD_REQ;
        pu_start_d = 1'b1;
        pu_op_d    = 1'b1;
        pu_a_d     = r0_d;
        pu_b_d     = r1_d;
      end

      if (enter_finish) begin
        state_d = S_FINISH;
        res_d   = r0_d;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      kreg_q     <= '0;
      idx_q      <= '0;
      r0_q       <= '0;
      r1_q       <= '0;
      t_q        <= '0;
      res_q      <= '0;
      pu_a_q     <= '0;
      pu_b_q     <= '0;
      pu_op_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pu_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kreg_q     <= kreg_d;
      idx_q      <= idx_d;
      r0_q       <= r0_d;
      r1_q       <= r1_d;
      t_q        <= t_d;
      res_q      <= res_d;
      pu_a_q     <= pu_a_d;
      pu_b_q     <= pu_b_d;
      pu_op_q    <= pu_op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pu_start_q <= pu_start_d;
    end
  end

  assign x2       = res_q.x;
  assign y2       = res_q.y;
  assign z2       = res_q.z;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pu_start = pu_start_q;
  assign pu_op    = pu_op_q;
  assign pu_ax    = pu_a_q.x;
  assign pu_ay    = pu_a_q.y;
  assign pu_az    = pu_a_q.z;
  assign pu_bx    = pu_b_q.x;
  assign pu_by    = pu_b_q.y;
  assign pu_bz    = pu_b_q.z;

endmodule

// File: tb/tb_pmul_ladder_ctrl.sv
// Bench for pmul_ladder_ctrl: one constant-time and one variable-time instance,
// each driving a fixed-latency integer point-unit stub.
module tb_pmul_ladder_ctrl;
  localparam int W      = 256;
  localparam int KW     = 256;
  localparam int L      = 3;
  localparam int BUDGET = 6000;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } pt_t;

  typedef struct {
    int           g;
    logic [KW-1:0] k;
    logic [W-1:0] x1;
    logic [W-1:0] z1;
    logic [W-1:0] ex;
    logic [W-1:0] ez;
    int           eops;
    int           elat;
    int           efirst;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start_s[2];
  logic          abort_s[2];
  logic          stray_s[2];
  logic [KW-1:0] k_s[2];
  logic [W-1:0]  x1_s[2], y1_s[2], z1_s[2];
  logic [W-1:0]  x2_s[2], y2_s[2], z2_s[2];
  logic          busy_s[2], done_s[2], pus_s[2], puop_s[2], pud_s[2];
  logic [W-1:0]  ax_s[2], ay_s[2], az_s[2], bx_s[2], by_s[2], bz_s[2];
  logic [W-1:0]  rx_s[2], ry_s[2], rz_s[2];
  int            ops_w[2], dones_w[2], bad_w[2];

  int checks   = 0;
  int failures = 0;

  // Integer "points": x carries the value, finite points have z = 1.
  function automatic pt_t stub_op(input logic op, input pt_t a, input pt_t b);
    pt_t r;
    r = a;
    if (op) begin
      if (a.z == '0)      r = b;
      else if (b.z == '0) r = a;
      else begin
        r.x = a.x + b.x;
        r.y = W'(1);
        r.z = W'(1);
      end
    end else if (a.z != '0) begin
      r.x = a.x << 1;
      r.y = W'(1);
      r.z = W'(1);
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    pt_t  res_l  = '0;
    pt_t  ha_l   = '0;
    pt_t  hb_l   = '0;
    logic hop_l  = 1'b0;
    logic pend_l = 1'b0;
    logic hold_l = 1'b0;
    logic sd_l   = 1'b0;
    int   cnt_l  = 0;
    int   ops_l  = 0;
    int   dn_l   = 0;
    int   bad_l  = 0;

    pmul_ladder_ctrl #(.W(W), .KW(KW), .CONST_TIME((gi == 0) ? 1 : 0)) u_dut (
      .clk(clk), .rstn(rstn), .start(start_s[gi]), .abort(abort_s[gi]), .k(k_s[gi]),
      .x1(x1_s[gi]), .y1(y1_s[gi]), .z1(z1_s[gi]),
      .x2(x2_s[gi]), .y2(y2_s[gi]), .z2(z2_s[gi]),
      .busy(busy_s[gi]), .done(done_s[gi]), .pu_start(pus_s[gi]), .pu_op(puop_s[gi]),
      .pu_ax(ax_s[gi]), .pu_ay(ay_s[gi]), .pu_az(az_s[gi]),
      .pu_bx(bx_s[gi]), .pu_by(by_s[gi]), .pu_bz(bz_s[gi]),
      .pu_done(pud_s[gi]), .pu_rx(rx_s[gi]), .pu_ry(ry_s[gi]), .pu_rz(rz_s[gi])
    );

    assign pud_s[gi]   = sd_l | stray_s[gi];
    assign rx_s[gi]    = res_l.x;
    assign ry_s[gi]    = res_l.y;
    assign rz_s[gi]    = res_l.z;
    assign ops_w[gi]   = ops_l;
    assign dones_w[gi] = dn_l;
    assign bad_w[gi]   = bad_l;

    // Point-unit stub: answers L cycles after the request, and watches that
    // the operands do not move while a request is outstanding.
    always @(posedge clk) begin
      sd_l <= 1'b0;
      if (done_s[gi]) dn_l <= dn_l + 1;
      if (hold_l) begin
        if (puop_s[gi] !== hop_l || {ax_s[gi], ay_s[gi], az_s[gi]} !== ha_l ||
            (hop_l && ({bx_s[gi], by_s[gi], bz_s[gi]} !== hb_l)))
          bad_l <= bad_l + 1;
        if (pud_s[gi]) hold_l <= 1'b0;
      end
      if (pus_s[gi]) begin
        ops_l  <= ops_l + 1;
        hold_l <= 1'b1;
        hop_l  <= puop_s[gi];
        ha_l   <= {ax_s[gi], ay_s[gi], az_s[gi]};
        hb_l   <= {bx_s[gi], by_s[gi], bz_s[gi]};
        res_l  <= stub_op(puop_s[gi], {ax_s[gi], ay_s[gi], az_s[gi]}, {bx_s[gi], by_s[gi], bz_s[gi]});
        cnt_l  <= L - 1;
        pend_l <= 1'b1;
      end else if (pend_l) begin
        if (cnt_l == 1) begin
          sd_l   <= 1'b1;
          pend_l <= 1'b0;
        end else begin
          cnt_l <= cnt_l - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one operation and follow it to done (or to the cycle budget).
  task automatic run_op(input int g, input logic [KW-1:0] kv, input logic [W-1:0] xv,
                        input logic [W-1:0] zv, input int inj,
                        output int nops, output int lat, output int first);
    int s, o0;
    @(posedge clk); #1;
    k_s[g] = kv; x1_s[g] = xv; y1_s[g] = W'(1); z1_s[g] = zv; start_s[g] = 1'b1;
    s = cyc; o0 = ops_w[g];
    lat = -1; first = -1;
    @(posedge clk); #1;
    start_s[g] = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      if (pus_s[g] && first < 0) first = cyc - s;
      if (done_s[g]) begin
        lat = cyc - s;
        break;
      end
      if (n == inj) begin
        k_s[g] = KW'(1); x1_s[g] = W'(9); start_s[g] = 1'b1;
      end else begin
        start_s[g] = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_s[g] = 1'b0;
    nops = ops_w[g] - o0;
  endtask

  initial begin
    vec_t          tbl[8];
    logic [W-1:0]  neg7;
    logic [KW-1:0] ones;
    int            nops, lat, first, seen, o0, d0;
    bit            found;

    ones = '1;
    neg7 = '0;
    neg7 = neg7 - W'(7);
    //          g  k         x1     z1     x2     z2     ops  lat   first
    tbl[0] = '{0, KW'(6),  W'(5), W'(1), W'(30), W'(1), 512, 2305, 1};
    tbl[1] = '{1, KW'(6),  W'(5), W'(1), W'(30), W'(1), 6,   281,  254};
    tbl[2] = '{0, KW'(0),  W'(5), W'(1), W'(1),  W'(0), 512, 2305, 1};
    tbl[3] = '{1, KW'(0),  W'(5), W'(1), W'(1),  W'(0), 0,   256,  -1};
    tbl[4] = '{0, KW'(6),  W'(1), W'(0), W'(1),  W'(0), 512, 2305, 1};
    tbl[5] = '{1, ones,    W'(7), W'(1), neg7,   W'(1), 512, 2305, 1};
    tbl[6] = '{1, KW'(1),  W'(9), W'(1), W'(9),  W'(1), 2,   265,  256};
    tbl[7] = '{0, ones,    W'(7), W'(1), neg7,   W'(1), 512, 2305, 1};

    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0; abort_s[g] = 1'b0; stray_s[g] = 1'b0;
      k_s[g] = '0; x1_s[g] = '0; y1_s[g] = W'(1); z1_s[g] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst%0d.busy", g), W'(busy_s[g]), W'(0));
      chk($sformatf("rst%0d.done", g), W'(done_s[g]), W'(0));
      chk($sformatf("rst%0d.pu_start", g), W'(pus_s[g]), W'(0));
      chk($sformatf("rst%0d.x2y2z2", g), x2_s[g] | y2_s[g] | z2_s[g], W'(0));
      chk($sformatf("rst%0d.pu_ops", g), ax_s[g] | ay_s[g] | az_s[g] | bx_s[g] | by_s[g] | bz_s[g] | W'(puop_s[g]), W'(0));
    end
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      d0 = dones_w[tbl[i].g];
      run_op(tbl[i].g, tbl[i].k, tbl[i].x1, tbl[i].z1, -1, nops, lat, first);
      repeat (2) @(posedge clk);
      #1;
      $display("row %0d inst=%0d ops=%0d lat=%0d first=%0d x2=%0h z2=%0h",
               i, tbl[i].g, nops, lat, first, x2_s[tbl[i].g], z2_s[tbl[i].g]);
      chk($sformatf("r%0d.x2", i), x2_s[tbl[i].g], tbl[i].ex);
      chk($sformatf("r%0d.z2", i), z2_s[tbl[i].g], tbl[i].ez);
      chk($sformatf("r%0d.ops", i), W'(nops), W'(tbl[i].eops));
      chk($sformatf("r%0d.latency", i), W'(lat), W'(tbl[i].elat));
      chk($sformatf("r%0d.first_pu_start", i), W'(first), W'(tbl[i].efirst));
      chk($sformatf("r%0d.done_count", i), W'(dones_w[tbl[i].g] - d0), W'(1));
    end

    // Abort two cycles into the double wait of bit 200 (the 112th request).
    @(posedge clk); #1;
    k_s[0] = ones; x1_s[0] = W'(5); z1_s[0] = W'(1); start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    seen = 0; found = 1'b0;
    for (int n = 0; n < BUDGET && !found; n++) begin
      if (pus_s[0]) begin
        seen++;
        if (seen == 112) found = 1'b1;
      end
      if (!found) begin
        @(posedge clk); #1;
      end
    end
    chk("abort.found_bit200_dbl", W'(found), W'(1));
    chk("abort.req_is_double", W'(puop_s[0]), W'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort_s[0] = 1'b1;
    d0 = dones_w[0];
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    chk("abort.busy_low", W'(busy_s[0]), W'(0));
    o0 = ops_w[0];
    repeat (6) @(posedge clk);
    #1;
    $display("abort at bit 200: busy=%0d x2=%0h z2=%0h", busy_s[0], x2_s[0], z2_s[0]);
    chk("abort.no_done", W'(dones_w[0] - d0), W'(0));
    chk("abort.no_new_req", W'(ops_w[0] - o0), W'(0));
    chk("abort.still_idle", W'(busy_s[0]), W'(0));
    chk("abort.x2_kept", x2_s[0], neg7);
    chk("abort.z2_kept", z2_s[0], W'(1));

    run_op(0, KW'(3), W'(4), W'(1), -1, nops, lat, first);
    #1;
    $display("after abort k=3 x1=4: ops=%0d lat=%0d x2=%0h", nops, lat, x2_s[0]);
    chk("post_abort.x2", x2_s[0], W'(12));
    chk("post_abort.ops", W'(nops), W'(512));

    // Same-cycle start and abort in IDLE: nothing starts.
    @(posedge clk); #1;
    k_s[0] = KW'(6); start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    $display("start+abort in idle: busy=%0d pu_start=%0d", busy_s[0], pus_s[0]);
    chk("start_abort.busy", W'(busy_s[0]), W'(0));
    chk("start_abort.pu_start", W'(pus_s[0]), W'(0));

    // Stray point-unit done pulses while idle, then a run with a start
    // pulse injected mid-operation.
    o0 = ops_w[0];
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1; stray_s[0] = 1'b1;
      @(posedge clk); #1; stray_s[0] = 1'b0;
    end
    chk("stray.busy", W'(busy_s[0]), W'(0));
    chk("stray.no_req", W'(ops_w[0] - o0), W'(0));
    d0 = dones_w[0];
    run_op(0, KW'(6), W'(5), W'(1), 20, nops, lat, first);
    repeat (2) @(posedge clk);
    #1;
    $display("restart-during-busy run: ops=%0d lat=%0d x2=%0h", nops, lat, x2_s[0]);
    chk("t6.x2", x2_s[0], W'(30));
    chk("t6.z2", z2_s[0], W'(1));
    chk("t6.ops", W'(nops), W'(512));
    chk("t6.latency", W'(lat), W'(2305));
    chk("t6.done_count", W'(dones_w[0] - d0), W'(1));
    chk("t6.operand_hold_ct", W'(bad_w[0]), W'(0));
    chk("t6.operand_hold_vt", W'(bad_w[1]), W'(0));

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    k_s[0] = KW'(6); x1_s[0] = W'(5); start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst.busy_before", W'(busy_s[0]), W'(1));
    d0 = dones_w[0];
    #2 rstn = 1'b0;
    #1;
    $display("mid-op reset: busy=%0d x2=%0h pu_start=%0d", busy_s[0], x2_s[0], pus_s[0]);
    chk("midrst.busy", W'(busy_s[0]), W'(0));
    chk("midrst.x2", x2_s[0], W'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst.no_done", W'(dones_w[0] - d0), W'(0));
    chk("midrst.idle", W'(busy_s[0] | pus_s[0]), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pmul_ladder_ctrl.md
Name: pmul_ladder_ctrl

Overview:
- Parametrised successor to point_mul. Computes Q = k·P by a Montgomery ladder over Jacobian points of width W and a KW-bit scalar.
- Does not contain field arithmetic. Sequences an external point unit (add/double) over a request/done handshake, so curve width and arithmetic latency are decoupled from control.
- Adds a constant-time mode, an abort input, and explicit point-at-infinity handling.

Parameters:
- W, 256, coordinate width in bits.
- KW, 256, scalar width in bits.
- CONST_TIME, 1: 1 = process all KW bits; 0 = skip leading zero bits of k.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; operands sampled the same cycle.
- abort  in  1  synchronous cancel of the current operation.
- k  in  KW  scalar.
- x1, y1, z1  in  W each  input point P (Jacobian; z1 = 0 means infinity).
- x2, y2, z2  out  W each  result Q.
- busy  out  1  high from the cycle after start until done/abort.
- done  out  1  one-cycle pulse; result valid.
- pu_start  out  1  one-cycle op request to the point unit.
- pu_op  out  1  0 = double(A), 1 = add(A,B).
- pu_ax, pu_ay, pu_az, pu_bx, pu_by, pu_bz  out  W each  operands.
- pu_done  in  1  point unit result valid (one-cycle pulse).
- pu_rx, pu_ry, pu_rz  in  W each  point unit result.

Behaviour:
- Reset (rstn low, async): state IDLE; R0, R1, x2/y2/z2, busy, done, pu_start, pu_op and all pu_* operands cleared to 0.
- Infinity constant INF = (1, 1, 0). The point unit must accept INF operands; the controller does not special-case them.
- IDLE: on start, latch k into kreg, set R0 = INF, R1 = (x1, y1, z1), bit index i = KW-1.
  - CONST_TIME=1: go to ADD_REQ.
  - CONST_TIME=0: go to SCAN.
- SCAN (CONST_TIME=0 only): one bit per cycle.
  - If kreg[i] = 0 and i > 0: decrement i.
  - If kreg[i] = 1: go to ADD_REQ.
  - If k = 0 (i reaches 0 with kreg[0] = 0): go to FINISH with R0 = INF.
- ADD_REQ: pulse pu_start with pu_op = 1, A = R0, B = R1; go to ADD_WAIT.
- ADD_WAIT: on pu_done, latch the result into T; go to DBL_REQ.
- DBL_REQ: pulse pu_start with pu_op = 0.
  - A = R0 if kreg[i] = 0, else A = R1.
  - B is don't-care.
  - Go to DBL_WAIT.
- DBL_WAIT: on pu_done, apply the update, then go to NEXT.
  - kreg[i] = 0: R1 = T, R0 = result.
  - kreg[i] = 1: R0 = T, R1 = result.
- NEXT: if i = 0, go to FINISH; else decrement i and go to ADD_REQ.
- FINISH: (x2, y2, z2) = R0, done = 1 for one cycle, busy = 0; return to IDLE.
- Outputs x2/y2/z2 hold their value until the next FINISH; they are not cleared by a new start.
- Operand hold: pu_a*, pu_b* and pu_op stay stable from the pu_start cycle until pu_done is sampled.
- pu_done must come at least 1 cycle after pu_start. pu_done outside ADD_WAIT/DBL_WAIT is ignored.
- Op count:
  - CONST_TIME=1: exactly 2·KW point-unit ops for any k, including k = 0.
  - CONST_TIME=0: 2·(KW - lz(k)) ops, where lz(k) is the number of leading zero bits of k.
- Latency with a point unit of fixed latency L (pu_done L cycles after pu_start): per bit = 2·(L + 1) + 1 cycles. Add 1 cycle for FINISH, plus SCAN cycles when CONST_TIME=0.
- start while busy: ignored.
- abort: any state → IDLE next cycle. No done pulse; busy drops; x2/y2/z2 keep their previous values. A late pu_done after abort is ignored.
- start and abort in the same cycle while IDLE: abort wins; start is ignored.
- rstn asserted mid-operation: immediate return to the reset state; no done.

Test Plan:
- Bench point-unit stub: "point" = integer in x, y = z = 1; INF has z = 0. add(a, b) returns x = a.x + b.x mod 2^W; double(a) returns 2·a.x. Either operand at INF returns the other operand.
- T1, CONST_TIME=1, KW=256, stub L=3: x1 = 5, z1 = 1, k = 6 → x2 = 30, z2 = 1, done once. Exactly 512 pu_start pulses; done 256·9 + 1 cycles after the start cycle.
- T2, CONST_TIME=0, same stimulus: x2 = 30. Exactly 6 ops (3 significant bits), 253 SCAN cycles before the first pu_start.
- T3: k = 0 → z2 = 0 (INF) in both modes. CONST_TIME=0: done 256 cycles after start, no pu_start. CONST_TIME=1: 512 ops.
- T4: z1 = 0 with k = 6 → z2 = 0. Also with x1 = 7, k = 2^256-1 → x2 = 7·(2^256-1) mod 2^256 = 2^256-7.
- T5: abort asserted 2 cycles into DBL_WAIT of bit 200 → busy low next cycle, no done, x2/y2/z2 unchanged from T4. A subsequent start with k = 3, x1 = 4 → x2 = 12.
- T6: start pulsed during busy, plus stray pu_done pulses in IDLE → ignored; result identical to T1; pu operands stable across every wait window.
